// File: rtl/llr_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : llr_pingpong_buf
// Description : Double-buffered LLR frame store. One bank fills from a
//               multi-lane sign-magnitude input stream while the decoder
//               reads the other bank through NRD random-access ports. Each
//               lane is saturated and converted to two's complement on write.
//               The two banks swap through a fill/release handshake.
// Ports       : i_clk, i_rst_n     clock, asynchronous active-low reset
//               i_in_valid/o_in_ready/i_in_data   LANES x (W+1) input beats
//               o_frame_valid      read bank holds a complete frame
//               i_frame_done       decoder releases the read bank (pulse)
//               i_rd_pos           NRD read addresses, AW bits each
//               o_rd_data          NRD registered read results, W bits each
// Revision    : 1.0 - initial release
// ============================================================================
module llr_pingpong_buf #(
    parameter int W     = 7,
    parameter int LANES = 8,
    parameter int DEPTH = 1023,
    parameter int NRD   = 6,
    parameter int AW    = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [LANES*(W+1)-1:0]   i_in_data,
    output logic                     o_frame_valid,
    input  logic                     i_frame_done,
    input  logic [NRD*AW-1:0]        i_rd_pos,
    output logic [NRD*W-1:0]         o_rd_data
);

    localparam int c_BEATS = (DEPTH + LANES - 1) / LANES;
    localparam int c_BW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LW    = W + 1;
    localparam logic [W-1:0]    c_MAG_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(c_BEATS - 1);

    // Bank state
    logic              r_wb_q,   w_wb_d;
    logic              r_rb_q,   w_rb_d;
    logic [1:0]        r_full_q, w_full_d;
    logic [c_BW-1:0]   r_beat_q, w_beat_d;
    logic [NRD*W-1:0]  r_rd_data_q, w_rd_data_d;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_release;

    // Storage is deliberately left without reset.
    logic [W-1:0]      r_mem [2][DEPTH];

    // Per-lane conversion and write index
    logic [W-1:0]      w_lane_val [LANES];
    logic [c_IW-1:0]   w_lane_idx [LANES];
    logic              w_lane_wen [LANES];

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
            logic [c_LW-1:0] w_raw;
            logic [W-1:0]    w_sat;
            logic [31:0]     w_lin;

            assign w_raw = i_in_data[j*c_LW +: c_LW];
            assign w_sat = (w_raw[W-1:0] > c_MAG_MAX) ? c_MAG_MAX : w_raw[W-1:0];
            // Negating a zero magnitude yields zero, so negative zero stores 0.
            assign w_lane_val[j] = w_raw[W] ? (~w_sat + W'(1)) : w_sat;
            assign w_lin         = 32'(r_beat_q) * 32'(LANES) + 32'(j);
            assign w_lane_idx[j] = w_lin[c_IW-1:0];
            // The final beat may overhang the frame; those lanes are dropped.
            assign w_lane_wen[j] = w_accept && (w_lin < 32'(DEPTH));
        end
    endgenerate

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_q      <= 1'b0;
            r_rb_q      <= 1'b0;
            r_full_q    <= 2'd0;
            r_beat_q    <= '0;
            r_rd_data_q <= '0;
        end else begin
            r_wb_q      <= w_wb_d;
            r_rb_q      <= w_rb_d;
            r_full_q    <= w_full_d;
            r_beat_q    <= w_beat_d;
            r_rd_data_q <= w_rd_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_lane_wen[k]) begin
                r_mem[r_wb_q][w_lane_idx[k]] <= w_lane_val[k];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_accept  = i_in_valid && w_in_ready;
        w_last    = w_accept && (r_beat_q == c_LAST_BEAT);
        w_release = i_frame_done && (r_full_q != 2'd0);

        w_beat_d  = r_beat_q;
        if (w_accept) begin
            w_beat_d = w_last ? '0 : (r_beat_q + c_BW'(1));
        end

        w_wb_d   = r_wb_q ^ w_last;
        w_rb_d   = r_rb_q ^ w_release;

        // Completion and release together leave the count unchanged.
        w_full_d = r_full_q;
        if (w_last && !w_release) begin
            w_full_d = r_full_q + 2'd1;
        end else if (!w_last && w_release) begin
            w_full_d = r_full_q - 2'd1;
        end

        // Reads use the current read bank, so a read on the releasing edge
        // still sees the frame being released.
        w_rd_data_d = '0;
        for (int p = 0; p < NRD; p++) begin
            if (32'(i_rd_pos[p*AW +: AW]) < 32'(DEPTH)) begin
                w_rd_data_d[p*W +: W] = r_mem[r_rb_q][i_rd_pos[p*AW +: c_IW]];
            end
        end
    end

    // Outputs
    always_comb begin
        w_in_ready    = (r_full_q != 2'd2);
        o_in_ready    = w_in_ready;
        o_frame_valid = (r_full_q != 2'd0);
        o_rd_data     = r_rd_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_llr_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_llr_pingpong_buf
// Description : Self-checking bench for llr_pingpong_buf. A reference model
//               of the banks predicts every read; predictions are queued when
//               addresses are driven and compared one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llr_pingpong_buf;

    localparam int W     = 7;
    localparam int LANES = 8;
    localparam int DEPTH = 1023;
    localparam int NRD   = 6;
    localparam int AW    = 10;
    localparam int BEATS = 128;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*8-1:0]     in_data;
    logic                   frame_valid;
    logic                   frame_done;
    logic [NRD*AW-1:0]      rd_pos;
    logic [NRD*W-1:0]       rd_data;

    always #5 clk = ~clk;

    llr_pingpong_buf #(
        .W(W), .LANES(LANES), .DEPTH(DEPTH), .NRD(NRD), .AW(AW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_frame_valid(frame_valid),
        .i_frame_done (frame_done),
        .i_rd_pos     (rd_pos),
        .o_rd_data    (rd_data)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [W-1:0] ref_bank  [2][DEPTH];
    bit           ref_known [2][DEPTH];
    bit           ref_wb, ref_rb;
    int           ref_full, ref_beat;

    // Raw input frames: 0 = conversion/boundary, 1..3 = random frames
    logic [7:0]   frame_raw [4][BEATS*LANES];

    typedef struct {
        bit   [NRD-1:0]   care;
        logic [NRD*W-1:0] exp;
    } sb_t;
    sb_t sb_q[$];

    function automatic logic [W-1:0] conv(input logic [7:0] raw);
        int m;
        int v;
        m = int'(raw[6:0]);
        if (m > 63) m = 63;
        v = raw[7] ? -m : m;
        return v[W-1:0];
    endfunction

    function automatic logic [LANES*8-1:0] beat_word(input int f, input int k);
        logic [LANES*8-1:0] d;
        for (int j = 0; j < LANES; j++) d[j*8 +: 8] = frame_raw[f][k*LANES + j];
        return d;
    endfunction

    task automatic set_rd(input int a0, input int a1, input int a2,
                          input int a3, input int a4, input int a5);
        rd_pos[0*AW +: AW] = AW'(a0);
        rd_pos[1*AW +: AW] = AW'(a1);
        rd_pos[2*AW +: AW] = AW'(a2);
        rd_pos[3*AW +: AW] = AW'(a3);
        rd_pos[4*AW +: AW] = AW'(a4);
        rd_pos[5*AW +: AW] = AW'(a5);
    endtask

    task automatic rand_rd();
        for (int p = 0; p < NRD; p++) rd_pos[p*AW +: AW] = AW'($urandom_range(0, 1030));
    endtask

    task automatic model_reset();
        ref_wb = 0; ref_rb = 0; ref_full = 0; ref_beat = 0;
        sb_q.delete();
    endtask

    // One clock: predict reads and update the model from the driven inputs,
    // advance, then compare the reads predicted for this edge.
    task automatic step();
        sb_t e;
        sb_t got;
        bit  acc, last, rel;
        int  a, idx;
        e.care = '0;
        e.exp  = '0;
        for (int p = 0; p < NRD; p++) begin
            a = int'(rd_pos[p*AW +: AW]);
            if (a >= DEPTH) begin
                e.care[p] = 1'b1;
            end else if (ref_known[ref_rb][a]) begin
                e.care[p] = 1'b1;
                e.exp[p*W +: W] = ref_bank[ref_rb][a];
            end
        end
        acc = in_valid && (ref_full != 2);
        if (acc) begin
            for (int j = 0; j < LANES; j++) begin
                idx = ref_beat * LANES + j;
                if (idx < DEPTH) begin
                    ref_bank[ref_wb][idx]  = conv(in_data[j*8 +: 8]);
                    ref_known[ref_wb][idx] = 1'b1;
                end
            end
        end
        last = acc && (ref_beat == BEATS - 1);
        if (acc) ref_beat = last ? 0 : ref_beat + 1;
        rel = frame_done && (ref_full != 0);
        if (last) ref_wb = ~ref_wb;
        if (rel)  ref_rb = ~ref_rb;
        ref_full = ref_full + int'(last) - int'(rel);
        sb_q.push_back(e);

        @(posedge clk);
        #1;

        got = sb_q.pop_front();
        for (int p = 0; p < NRD; p++) begin
            if (got.care[p]) begin
                checks++;
                if (rd_data[p*W +: W] !== got.exp[p*W +: W]) begin
                    failures++;
                    $display("FAIL sb_rd port %0d: got %h want %h", p,
                             rd_data[p*W +: W], got.exp[p*W +: W]);
                end
            end
        end
        checks++;
        if (in_ready !== (ref_full != 2)) begin
            failures++;
            $display("FAIL sb_ready: got %b want %b", in_ready, (ref_full != 2));
        end
        checks++;
        if (frame_valid !== (ref_full != 0)) begin
            failures++;
            $display("FAIL sb_frame_valid: got %b want %b", frame_valid, (ref_full != 0));
        end
    endtask

    task automatic load_frame(input int f, input int k0, input bit done_on_last);
        for (int k = k0; k < BEATS; k++) begin
            in_valid   = 1'b1;
            in_data    = beat_word(f, k);
            frame_done = done_on_last && (k == BEATS - 1);
            rand_rd();
            step();
        end
        in_valid   = 1'b0;
        frame_done = 1'b0;
    endtask

    task automatic build_frames();
        logic [7:0] c_lanes [8];
        c_lanes = '{8'h85, 8'h05, 8'hFF, 8'h7F, 8'h80, 8'hC0, 8'h3F, 8'h00};
        for (int i = 0; i < BEATS*LANES; i++) begin
            frame_raw[0][i] = 8'h00;
            for (int f = 1; f < 4; f++) frame_raw[f][i] = 8'($urandom);
        end
        for (int j = 0; j < LANES; j++) begin
            frame_raw[0][j]                       = c_lanes[j];
            frame_raw[0][(BEATS-1)*LANES + j]     = 8'(j + 1);
            frame_raw[2][j]                       = 8'h22;
            frame_raw[3][j]                       = 8'h11;
        end
    endtask

    task automatic test_reset();
        // Partially load a frame, then reset in the middle of it.
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = beat_word(1, k);
            rand_rd();
            step();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++;
        if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
        checks++;
        if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        @(posedge clk);
        #1;
        checks++;
        if (rd_data !== '0 || in_ready !== 1'b1 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: rd %h ready %b fvalid %b want 0/1/0", rd_data, in_ready, frame_valid);
        end
        in_valid = 1'b0;
        model_reset();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_conversion();
        logic [W-1:0] exp_c [8];
        exp_c = '{7'h7B, 7'h05, 7'h41, 7'h3F, 7'h00, 7'h41, 7'h3F, 7'h00};
        set_rd(0, 0, 0, 0, 0, 0);
        load_frame(0, 0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1) begin failures++; $display("FAIL conv_frame_valid: got %b want 1", frame_valid); end
        set_rd(0, 1, 2, 3, 4, 5);
        step();
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== exp_c[p]) begin
                failures++;
                $display("FAIL conv_idx%0d: got %h want %h", p, rd_data[p*W +: W], exp_c[p]);
            end
        end
        set_rd(6, 7, 0, 0, 0, 0);
        step();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== exp_c[p+6]) begin
                failures++;
                $display("FAIL conv_idx%0d: got %h want %h", p + 6, rd_data[p*W +: W], exp_c[p+6]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] exp_b [6];
        exp_b = '{7'h7B, 7'h7B, 7'h07, 7'h00, 7'h41, 7'h07};
        set_rd(0, 0, 1022, 1023, 5, 1022);
        step();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== exp_b[p]) begin
                failures++;
                $display("FAIL boundary_port%0d: got %h want %h", p, rd_data[p*W +: W], exp_b[p]);
            end
        end
        set_rd(1023, 1023, 1023, 1023, 1023, 1023);
        step();
        checks++;
        if (rd_data !== '0) begin failures++; $display("FAIL boundary_latency: got %h want 0", rd_data); end
    endtask

    task automatic test_backpressure();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        load_frame(1, 0, 1'b0);
        load_frame(2, 0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
        // Beat 257 is presented and held while stalled.
        in_valid = 1'b1;
        in_data  = beat_word(3, 0);
        for (int i = 0; i < 3; i++) begin
            rand_rd();
            step();
        end
        set_rd(0, 1, 2, 3, 4, 5);
        step();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== conv(frame_raw[1][p])) begin
                failures++;
                $display("FAIL bp_stall_frame1_idx%0d: got %h want %h", p, rd_data[p*W +: W], conv(frame_raw[1][p]));
            end
        end
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: ready %b fvalid %b want 1/1", in_ready, frame_valid);
        end
        step();
        in_valid = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== conv(frame_raw[2][p])) begin
                failures++;
                $display("FAIL bp_frame2_idx%0d: got %h want %h", p, rd_data[p*W +: W], conv(frame_raw[2][p]));
            end
        end
    endtask

    task automatic test_simultaneous();
        load_frame(3, 1, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sim_flags: fvalid %b ready %b want 1/1", frame_valid, in_ready);
        end
        set_rd(0, 1, 2, 3, 4, 5);
        step();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== 7'h11) begin
                failures++;
                $display("FAIL sim_new_frame_idx%0d: got %h want 11", p, rd_data[p*W +: W]);
            end
        end
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        checks++;
        if (frame_valid !== 1'b0) begin failures++; $display("FAIL sim_empty: got %b want 0", frame_valid); end
        // Spurious release with nothing valid must change nothing.
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        step();
        checks++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sim_spurious_flags: fvalid %b ready %b want 0/1", frame_valid, in_ready);
        end
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*W +: W] !== 7'h22) begin
                failures++;
                $display("FAIL sim_spurious_rb_idx%0d: got %h want 22", p, rd_data[p*W +: W]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        frame_done = 1'b0;
        rd_pos     = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) ref_known[b][i] = 1'b0;
        build_frames();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        test_reset();
        test_conversion();
        test_boundary();
        test_backpressure();
        test_simultaneous();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/llr_pingpong_buf.md
# llr_pingpong_buf

Double-buffered LLR frame store between the channel-input bus and the decoder core. One bank is filled from a multi-lane sign-magnitude input stream while the decoder reads the other bank through NRD independent random-access ports. Each lane is converted to saturated two's complement on write. Banks swap by handshake, so the next codeword loads while the current one is decoded.

## Interface
- W, 7: output LLR width (two's complement); input lane is W+1 bits (bit W = sign, bits W-1:0 = magnitude)
- LANES, 8: LLR lanes per input beat
- DEPTH, 1023: LLR entries per frame (per bank)
- NRD, 6: number of read ports
- AW, 10: read address width, at least clog2(DEPTH)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_in_valid  in  1  input beat valid
- o_in_ready  out  1  input beat accepted when valid&ready
- i_in_data  in  LANES*(W+1)  lane j at bits [j*(W+1) +: W+1]
- o_frame_valid  out  1  read bank holds a complete frame
- i_frame_done  in  1  single-cycle pulse: decoder releases the read bank
- i_rd_pos  in  NRD*AW  port p address at [p*AW +: AW]
- o_rd_data  out  NRD*W  port p data at [p*W +: W], registered

## Operation
- BEATS = ceil(DEPTH/LANES); 128 at defaults.
- State:
  - wb: write-bank pointer.
  - rb: read-bank pointer.
  - full_cnt: number of full banks, 0..2.
  - beat_cnt: 0..BEATS-1.
- o_in_ready = (full_cnt != 2).
- Accepted beat k writes lane j to bank wb, index k*LANES+j. Indices >= DEPTH are discarded; at defaults, beat 127 lane 7 (index 1023) is dropped.
- Lane conversion:
  - mag' = min(mag, 2^(W-1)-1). At W=7 the ceiling is 63.
  - Output = sign ? -mag' : mag'.
  - Negative zero (0x80) stores 0.
- Accept on beat_cnt = BEATS-1 completes the frame: beat_cnt returns to 0, wb toggles, full_cnt increments.
- o_frame_valid = (full_cnt != 0).
- i_frame_done with o_frame_valid = 1: rb toggles, full_cnt decrements.
- i_frame_done with o_frame_valid = 0: ignored, no state change.
- Frame completion and valid i_frame_done in the same cycle: full_cnt unchanged, both wb and rb toggle.
- Read ports always address bank rb, including while o_frame_valid = 0.
  - In-range address (< DEPTH): return the stored value (stale data when the bank is not valid).
  - Address >= DEPTH: return 0.
- All ports are independent; any ports may share an address.
- Storage arrays are not reset; unwritten entries are undefined.
- Reset (async): wb=0, rb=0, full_cnt=0, beat_cnt=0, all o_rd_data=0.
- Reset mid-frame discards the partial frame and both full banks.
- Input lanes never alias read data: the write bank is never the valid read bank.

## Timing
- Outputs after reset: o_in_ready=1, o_frame_valid=0, o_rd_data=0.
- Write: the entry is updated at the accepting edge.
- Frame visibility: o_frame_valid rises the cycle after the edge that accepts the last beat. Read data from that frame is available one further edge later.
- Read latency is exactly 1 cycle: i_rd_pos sampled at edge t appears on o_rd_data after edge t.
- A read sampled on the same edge as an accepted i_frame_done uses the old rb.
- Backpressure:
  - o_in_ready falls the cycle after the second full frame completes.
  - It rises the cycle after the releasing i_frame_done.
  - i_in_data is held by the source while stalled; beats presented while ready=0 are ignored.
- Throughput: 1 beat/cycle. Back-to-back frames need no gap while full_cnt < 2.

## Test plan
- Reset: hold i_rst_n=0 mid-stream, then release.
  - During reset: o_in_ready=1, o_frame_valid=0, o_rd_data=0.
  - After release: beat_cnt=0; next beat writes indices 0..7.
- Conversion: frame with beat 0 lanes = 0x85, 0x05, 0xFF, 0x7F, 0x80, 0xC0, 0x3F, 0x00, other beats 0.
  - Indices 0..7 read 0x7B, 0x05, 0x41, 0x3F, 0x00, 0x41, 0x3F, 0x00.
- Boundary and latency:
  - Beat 127 lanes 0..7 = 0x01..0x08: index 1022 reads 0x07; index 1023 reads 0.
  - Six ports at 0, 0, 1022, 1023, 5, 1022 return correct values exactly 1 cycle after sampling.
- Backpressure: load 256 beats with no i_frame_done.
  - o_in_ready=0 from the cycle after beat 256; beat 257 held, not written.
  - Pulse i_frame_done: o_in_ready=1 next cycle; o_frame_valid stays 1; reads now return frame 2 data.
- Simultaneous events: with full_cnt=1, assert i_frame_done on the cycle the last beat of the next frame is accepted.
  - o_frame_valid stays 1; next read returns the new frame; o_in_ready stays 1.
  - i_frame_done while o_frame_valid=0 leaves state unchanged.
